// File: rtl/kfps2kb_pkg.sv
// Shared types and byte constants for the PS/2 scan-code-set-2 decoder.
// Covers prefix bytes, device status bytes and the key event record stored in the FIFO.
package kfps2kb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK,
      ST_PAUSE
   } dec_state_t;

   localparam logic [7:0] PREFIX_E0    = 8'hE0;
   localparam logic [7:0] PREFIX_F0    = 8'hF0;
   localparam logic [7:0] PREFIX_E1    = 8'hE1;
   localparam logic [7:0] FAKE_SHIFT_L = 8'h12;
   localparam logic [7:0] FAKE_SHIFT_R = 8'h59;

   localparam logic [7:0] STATUS_BAT_OK   = 8'hAA;
   localparam logic [7:0] STATUS_BAT_FAIL = 8'hFC;
   localparam logic [7:0] STATUS_ACK      = 8'hFA;
   localparam logic [7:0] STATUS_ECHO     = 8'hEE;
   localparam logic [7:0] STATUS_RESEND   = 8'hFE;
   localparam logic [7:0] STATUS_ERR_00   = 8'h00;
   localparam logic [7:0] STATUS_ERR_FF   = 8'hFF;

   // The pause key sends E1 followed by seven more bytes that carry no extra information.
   localparam logic [2:0] PAUSE_SKIP = 3'd7;

   typedef struct packed {
      logic       extended;
      logic       brk;
      logic [7:0] code;
   } key_event_t;

   function automatic logic is_status_byte(input logic [7:0] b);
      return (b == STATUS_BAT_OK) || (b == STATUS_BAT_FAIL) || (b == STATUS_ACK) ||
             (b == STATUS_ECHO)   || (b == STATUS_RESEND)   || (b == STATUS_ERR_00) ||
             (b == STATUS_ERR_FF);
   endfunction

   function automatic logic is_fake_shift(input logic [7:0] b);
      return (b == FAKE_SHIFT_L) || (b == FAKE_SHIFT_R);
   endfunction

endpackage

// File: rtl/kfps2kb_event_fifo.sv
// First-word-fall-through FIFO of decoded key events.
// A push while full is accepted only when a pop frees a slot on the same edge.
module kfps2kb_event_fifo
   import kfps2kb_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          push,
   input  key_event_t    push_data,
   input  logic          pop,
   output key_event_t    head,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   key_event_t    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == FULL_COUNT);
   assign count   = count_q;
   assign head    = mem_q[rd_ptr_q];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately left out of reset; occupancy guards every read of it.
   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/kfps2kb_scancode_decoder.sv
// Decodes PS/2 set-2 prefix sequences (E0/F0/E1) into single key events,
// diverts device status bytes to a pulse port and queues events for the host.
module kfps2kb_scancode_decoder
   import kfps2kb_pkg::*;
#(
   parameter logic [15:0] prefix_timeout = 16'd60000,
   parameter int unsigned fifo_depth     = 8
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [7:0]                    scancode,
   input  logic                          scancode_valid,
   input  logic                          scancode_error,
   output logic [7:0]                    event_code,
   output logic                          event_extended,
   output logic                          event_break,
   output logic                          event_valid,
   input  logic                          event_ready,
   output logic [7:0]                    status_code,
   output logic                          status_valid,
   output logic                          overflow,
   output logic [$clog2(fifo_depth):0]   event_count
);

   dec_state_t  state_q, state_d;
   logic [15:0] tmo_q, tmo_d, tmo_inc;
   logic [2:0]  skip_q, skip_d;
   logic [7:0]  status_code_q, status_code_d;
   logic        status_valid_q, status_valid_d;
   logic        overflow_q, overflow_d;

   logic        push, pop, fifo_full, fifo_empty;
   key_event_t  push_ev, head_ev;
   logic        byte_in;

   // An error pulse wins over a coincident good byte.
   assign byte_in = scancode_valid && !scancode_error;

   // State register
   // NOTE: sequential state uses non-blocking assignments only; comb blocks use blocking.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         tmo_q          <= '0;
         skip_q         <= '0;
         status_code_q  <= '0;
         status_valid_q <= 1'b0;
         overflow_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         tmo_q          <= tmo_d;
         skip_q         <= skip_d;
         status_code_q  <= status_code_d;
         status_valid_q <= status_valid_d;
         overflow_q     <= overflow_d;
      end
   end

   // Next-state logic
   // NOTE: every comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      skip_d  = skip_q;
      tmo_inc = tmo_q + 16'd1;
      if (scancode_error) begin
         state_d = ST_IDLE;
         tmo_d   = '0;
         skip_d  = '0;
      end else if (scancode_valid) begin
         tmo_d = '0;
         case (state_q)
            ST_IDLE: begin
               if (scancode == PREFIX_E0)      state_d = ST_EXT;
               else if (scancode == PREFIX_F0) state_d = ST_BRK;
               else if (scancode == PREFIX_E1) begin
                  state_d = ST_PAUSE;
                  skip_d  = PAUSE_SKIP;
               end
            end
            ST_EXT: begin
               if (scancode == PREFIX_E0)      state_d = ST_EXT;
               else if (scancode == PREFIX_F0) state_d = ST_EXT_BRK;
               else                            state_d = ST_IDLE;
            end
            ST_BRK:     state_d = (scancode == PREFIX_F0) ? ST_BRK : ST_IDLE;
            ST_EXT_BRK: state_d = ST_IDLE;
            ST_PAUSE: begin
               skip_d = skip_q - 3'd1;
               if (skip_q == 3'd1) state_d = ST_IDLE;
            end
            default:    state_d = ST_IDLE;
         endcase
      end else if (state_q != ST_IDLE) begin
         if (tmo_inc >= prefix_timeout) begin
            state_d = ST_IDLE;
            tmo_d   = '0;
            skip_d  = '0;
         end else begin
            tmo_d = tmo_inc;
         end
      end
   end

   // Output logic: event pushes and status/overflow pulses
   always_comb begin
      push           = 1'b0;
      push_ev        = '0;
      push_ev.code   = scancode;
      status_code_d  = status_code_q;
      status_valid_d = 1'b0;
      if (byte_in) begin
         case (state_q)
            ST_IDLE: begin
               if (is_status_byte(scancode)) begin
                  status_code_d  = scancode;
                  status_valid_d = 1'b1;
               end else if (scancode != PREFIX_E0 && scancode != PREFIX_F0 &&
                            scancode != PREFIX_E1) begin
                  push = 1'b1;
               end
            end
            ST_EXT: begin
               push_ev.extended = 1'b1;
               push = (scancode != PREFIX_E0) && (scancode != PREFIX_F0) &&
                      !is_fake_shift(scancode);
            end
            ST_BRK: begin
               push_ev.brk = 1'b1;
               push        = (scancode != PREFIX_F0);
            end
            ST_EXT_BRK: begin
               push_ev.extended = 1'b1;
               push_ev.brk      = 1'b1;
               push             = !is_fake_shift(scancode);
            end
            ST_PAUSE: begin
               push_ev.code = PREFIX_E1;
               push         = (skip_q == 3'd1);
            end
            default: push = 1'b0;
         endcase
      end
   end

   assign pop        = event_ready && !fifo_empty;
   assign overflow_d = push && fifo_full && !pop;

   kfps2kb_event_fifo #(
      .DEPTH (fifo_depth)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data (push_ev),
      .pop       (pop),
      .head      (head_ev),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (event_count)
   );

   // Head fields read as zero while empty so the outputs never expose unwritten storage.
   assign event_valid    = !fifo_empty;
   assign event_code     = fifo_empty ? 8'h00 : head_ev.code;
   assign event_extended = !fifo_empty && head_ev.extended;
   assign event_break    = !fifo_empty && head_ev.brk;
   assign status_code    = status_code_q;
   assign status_valid   = status_valid_q;
   assign overflow       = overflow_q;

endmodule

// File: tb/tb_kfps2kb_scancode_decoder.sv
// Directed bench for the scan-code decoder: prefix grammar, status filtering,
// timeout/error abort, FIFO overflow and wrap, and asynchronous reset.
module tb_kfps2kb_scancode_decoder;

   localparam logic [15:0] TMO   = 16'd20;
   localparam int unsigned DEPTH = 8;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] scancode = 8'h00;
   logic       scancode_valid = 1'b0;
   logic       scancode_error = 1'b0;
   logic [7:0] event_code;
   logic       event_extended;
   logic       event_break;
   logic       event_valid;
   logic       event_ready = 1'b0;
   logic [7:0] status_code;
   logic       status_valid;
   logic       overflow;
   logic [3:0] event_count;

   int n_vec = 0;
   int n_err = 0;

   kfps2kb_scancode_decoder #(
      .prefix_timeout (TMO),
      .fifo_depth     (DEPTH)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .scancode       (scancode),
      .scancode_valid (scancode_valid),
      .scancode_error (scancode_error),
      .event_code     (event_code),
      .event_extended (event_extended),
      .event_break    (event_break),
      .event_valid    (event_valid),
      .event_ready    (event_ready),
      .status_code    (status_code),
      .status_valid   (status_valid),
      .overflow       (overflow),
      .event_count    (event_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // All helpers start and end on a falling edge; the rising edge in between samples inputs.
   task automatic send(input logic [7:0] b);
      scancode       = b;
      scancode_valid = 1'b1;
      @(negedge clock);
      scancode_valid = 1'b0;
   endtask

   task automatic err_pulse();
      scancode_error = 1'b1;
      @(negedge clock);
      scancode_error = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic pop_head(input string tag, input logic ext, input logic brk, input logic [7:0] code);
      check({tag, ".valid"}, 32'(event_valid), 32'd1);
      check({tag, ".ext"},   32'(event_extended), 32'(ext));
      check({tag, ".brk"},   32'(event_break), 32'(brk));
      check({tag, ".code"},  32'(event_code), 32'(code));
      event_ready = 1'b1;
      @(negedge clock);
      event_ready = 1'b0;
   endtask

   initial begin
      // Reset state
      idle(2);
      check("rst.valid",  32'(event_valid), 32'd0);
      check("rst.count",  32'(event_count), 32'd0);
      check("rst.code",   32'(event_code), 32'd0);
      check("rst.status", 32'(status_valid), 32'd0);
      check("rst.scode",  32'(status_code), 32'd0);
      check("rst.ovf",    32'(overflow), 32'd0);
      reset = 1'b0;
      idle(1);

      // Make, then break of the same key; one-cycle latency to event_valid
      send(8'h1C);
      check("make.lat", 32'(event_valid), 32'd1);
      send(8'hF0);
      send(8'h1C);
      check("mk_brk.count", 32'(event_count), 32'd2);
      pop_head("mk", 1'b0, 1'b0, 8'h1C);
      pop_head("brk", 1'b0, 1'b1, 8'h1C);
      check("mk_brk.empty", 32'(event_count), 32'd0);

      // Extended break, plain extended, repeated prefixes
      send(8'hE0); send(8'hF0); send(8'h75);
      check("extbrk.count", 32'(event_count), 32'd1);
      pop_head("extbrk", 1'b1, 1'b1, 8'h75);
      send(8'hE0); send(8'hE0); send(8'h75);
      pop_head("ext_e0e0", 1'b1, 1'b0, 8'h75);
      send(8'hF0); send(8'hF0); send(8'h1C);
      pop_head("brk_f0f0", 1'b0, 1'b1, 8'h1C);

      // Fake shifts are discarded and the decoder is back in IDLE
      send(8'hE0); send(8'h12);
      send(8'hE0); send(8'hF0); send(8'h59);
      check("fake.count", 32'(event_count), 32'd0);
      send(8'h1C);
      pop_head("after_fake", 1'b0, 1'b0, 8'h1C);

      // Pause: eight bytes give exactly one E1 event, only on the last byte
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0);
      check("pause.early", 32'(event_count), 32'd0);
      send(8'h77);
      check("pause.count", 32'(event_count), 32'd1);
      pop_head("pause", 1'b0, 1'b0, 8'hE1);

      // Status bytes pulse for one cycle and push nothing
      send(8'hAA);
      check("stat.valid", 32'(status_valid), 32'd1);
      check("stat.code",  32'(status_code), 32'hAA);
      check("stat.noev",  32'(event_count), 32'd0);
      idle(1);
      check("stat.pulse", 32'(status_valid), 32'd0);
      send(8'hFA);
      check("stat2.code", 32'(status_code), 32'hFA);

      // Timeout: one cycle short keeps the prefix, the full budget drops it
      send(8'hE0); idle(int'(TMO) - 1); send(8'h1C);
      pop_head("tmo_short", 1'b1, 1'b0, 8'h1C);
      send(8'hE0); idle(int'(TMO)); send(8'h1C);
      pop_head("tmo_full", 1'b0, 1'b0, 8'h1C);

      // Error pulse aborts a partial sequence; error beats a coincident byte
      send(8'hF0); err_pulse(); send(8'h1C);
      pop_head("err_abort", 1'b0, 1'b0, 8'h1C);
      send(8'hE0);
      scancode = 8'h33; scancode_valid = 1'b1; scancode_error = 1'b1;
      @(negedge clock);
      scancode_valid = 1'b0; scancode_error = 1'b0;
      check("err_prio.count", 32'(event_count), 32'd0);
      send(8'h1C);
      pop_head("err_prio", 1'b0, 1'b0, 8'h1C);

      // Push into an empty FIFO with ready high: no bypass, pop one cycle later
      event_ready = 1'b1;
      send(8'h2A);
      check("nobypass.count", 32'(event_count), 32'd1);
      idle(1);
      event_ready = 1'b0;
      check("nobypass.pop", 32'(event_count), 32'd0);

      // Overflow: nine pushes, eight stored, one pulse
      for (int i = 0; i < 8; i++) send(8'h10 + 8'(i));
      check("ovf.before", 32'(overflow), 32'd0);
      send(8'h18);
      check("ovf.pulse", 32'(overflow), 32'd1);
      check("ovf.count", 32'(event_count), 32'd8);
      idle(1);
      check("ovf.once", 32'(overflow), 32'd0);

      // Push with simultaneous pop while full is accepted
      event_ready = 1'b1;
      send(8'h20);
      event_ready = 1'b0;
      check("fullpp.count", 32'(event_count), 32'd8);
      check("fullpp.ovf",   32'(overflow), 32'd0);
      for (int i = 1; i < 8; i++) pop_head("wrap", 1'b0, 1'b0, 8'h10 + 8'(i));
      pop_head("wrap_last", 1'b0, 1'b0, 8'h20);
      check("wrap.empty", 32'(event_valid), 32'd0);

      // Asynchronous reset mid-sequence with a queued event
      send(8'h1C); send(8'hE0);
      #2 reset = 1'b1;
      #1;
      check("arst.count", 32'(event_count), 32'd0);
      check("arst.valid", 32'(event_valid), 32'd0);
      check("arst.scode", 32'(status_code), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      idle(1);
      send(8'h1C);
      pop_head("arst_after", 1'b0, 1'b0, 8'h1C);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
